btn_event_ctrl: RTL and testbench

Front-end controller for the board push-buttons. It samples N raw button inputs at a divided tick rate and debounces each one. Every debounced press becomes a one-shot event, and a round-robin arbiter serialises simultaneous presses onto a single valid/ready event port. The port feeds the top-level game/menu FSM.

---
 rtl/btn_pkg.sv | 13 +
 rtl/btn_filter.sv | 99 +++++++++
 rtl/btn_event_ctrl.sv | 122 ++++++++++++
 tb/tb_btn_event_ctrl.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/btn_pkg.sv
// Shared constants and arbiter state encoding for the push-button event front-end.
package btn_pkg;

  localparam int TICK_DIV_DEF       = 100000;
  localparam int STABLE_SAMPLES_DEF = 3;
  localparam int REPEAT_TICKS_DEF   = 50;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_PRESENT = 1'b1
  } arb_state_t;

endpackage

// File: rtl/btn_filter.sv
// One button: 2-flop synchronizer, tick-sampled debounce history, level register, press pulse.
// Optional hold-to-repeat counter under BTN_AUTOREPEAT_EN.
module btn_filter
  import btn_pkg::*;
#(
  parameter int STABLE_SAMPLES = STABLE_SAMPLES_DEF
`ifdef BTN_AUTOREPEAT_EN
  , parameter int REPEAT_TICKS = REPEAT_TICKS_DEF
`endif
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  input  logic tick,
  output logic level,
  output logic press
);

  logic                      sync1_q, sync1_d;
  logic                      sync2_q, sync2_d;
  logic [STABLE_SAMPLES-1:0] hist_q, hist_d;
  logic                      level_q, level_d;
  logic                      level_dly_q, level_dly_d;
  logic                      rise;

  always_comb begin
    sync1_d     = btn_raw;
    sync2_d     = sync1_q;
    hist_d      = hist_q;
    level_d     = level_q;
    level_dly_d = level_q;
    if (tick) begin
      hist_d = {hist_q[STABLE_SAMPLES-2:0], sync2_q};
      if (&hist_d) begin
        level_d = 1'b1;
      end else if (~|hist_d) begin
        level_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      hist_q      <= '0;
      level_q     <= 1'b0;
      level_dly_q <= 1'b0;
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      hist_q      <= hist_d;
      level_q     <= level_d;
      level_dly_q <= level_dly_d;
    end
  end

  assign rise  = level_q & ~level_dly_q;
  assign level = level_q;

`ifdef BTN_AUTOREPEAT_EN
  localparam int HW = $clog2(REPEAT_TICKS + 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(REPEAT_TICKS - 1);

  logic [HW-1:0] hold_q, hold_d;
  logic          rep_q, rep_d;

  // The repeat pulse is registered so it lands one clk after its tick, like a debounced edge.
  always_comb begin
    hold_d = hold_q;
    rep_d  = 1'b0;
    if (!level_q) begin
      hold_d = '0;
    end else if (tick) begin
      if (hold_q == HOLD_LAST) begin
        hold_d = '0;
        rep_d  = 1'b1;
      end else begin
        hold_d = hold_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_q <= '0;
      rep_q  <= 1'b0;
    end else begin
      hold_q <= hold_d;
      rep_q  <= rep_d;
    end
  end

  assign press = rise | rep_q;
`else
  assign press = rise;
`endif

endmodule

// File: rtl/btn_event_ctrl.sv
// Debounces N_BTN buttons and serialises presses round-robin onto one valid/ready event port.
// BTN_AUTOREPEAT_EN adds per-button hold-to-repeat events (REPEAT_TICKS exists only then).
module btn_event_ctrl
  import btn_pkg::*;
#(
  parameter int N_BTN          = 4,
  parameter int TICK_DIV       = TICK_DIV_DEF,
  parameter int STABLE_SAMPLES = STABLE_SAMPLES_DEF
`ifdef BTN_AUTOREPEAT_EN
  , parameter int REPEAT_TICKS = REPEAT_TICKS_DEF
`endif
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_BTN-1:0]         btn_in,
  output logic [N_BTN-1:0]         btn_level,
  output logic                     evt_valid,
  input  logic                     evt_ready,
  output logic [$clog2(N_BTN)-1:0] evt_id,
  output logic                     overrun
);

  localparam int IDW = $clog2(N_BTN);
  localparam int TW  = $clog2(TICK_DIV);
  localparam logic [TW-1:0]  TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [IDW-1:0] LAST_ID   = IDW'(N_BTN - 1);

  logic [TW-1:0]    tick_cnt_q, tick_cnt_d;
  logic             tick;
  logic [N_BTN-1:0] press;
  logic [N_BTN-1:0] pending_q, pending_d;
  logic [N_BTN-1:0] clr;
  logic             overrun_q, overrun_d;
  logic [IDW-1:0]   evt_id_q, evt_id_d;
  logic [IDW-1:0]   last_grant_q, last_grant_d;
  arb_state_t       state_q, state_d;
  logic [IDW-1:0]   cand, pick;
  logic             found;
  logic             grant;

  always_comb begin
    tick       = (tick_cnt_q == TICK_LAST);
    tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;
  end

  for (genvar i = 0; i < N_BTN; i++) begin : g_btn
    btn_filter #(
      .STABLE_SAMPLES(STABLE_SAMPLES)
`ifdef BTN_AUTOREPEAT_EN
      , .REPEAT_TICKS(REPEAT_TICKS)
`endif
    ) u_filter (
      .clk    (clk),
      .rst    (rst),
      .btn_raw(btn_in[i]),
      .tick   (tick),
      .level  (btn_level[i]),
      .press  (press[i])
    );
  end

  // Round-robin search starting just above the last granted button.
  always_comb begin
    found = 1'b0;
    pick  = last_grant_q;
    cand  = last_grant_q;
    for (int k = 0; k < N_BTN; k++) begin
      cand = (cand == LAST_ID) ? '0 : cand + 1'b1;
      if (!found && pending_q[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (found) state_d = ST_PRESENT;
      ST_PRESENT: if (evt_ready && !found) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    evt_valid = (state_q == ST_PRESENT);
    grant     = found && ((state_q == ST_IDLE) || evt_ready);
  end

  // A press landing on a still-pending button is lost unless that button is being granted now.
  always_comb begin
    for (int j = 0; j < N_BTN; j++) begin
      clr[j] = grant && (pick == IDW'(j));
    end
    pending_d    = (pending_q & ~clr) | press;
    overrun_d    = overrun_q | (|(press & pending_q & ~clr));
    evt_id_d     = grant ? pick : evt_id_q;
    last_grant_d = grant ? pick : last_grant_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      tick_cnt_q   <= '0;
      pending_q    <= '0;
      overrun_q    <= 1'b0;
      evt_id_q     <= '0;
      last_grant_q <= LAST_ID;
    end else begin
      state_q      <= state_d;
      tick_cnt_q   <= tick_cnt_d;
      pending_q    <= pending_d;
      overrun_q    <= overrun_d;
      evt_id_q     <= evt_id_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign evt_id  = evt_id_q;
  assign overrun = overrun_q;

endmodule

// File: tb/tb_btn_event_ctrl.sv
// Directed bench for btn_event_ctrl with TICK_DIV=4, STABLE_SAMPLES=3, N_BTN=4 (REPEAT_TICKS=5 when enabled).
module tb_btn_event_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] btn_in;
  logic [3:0] btn_level;
  logic       evt_valid;
  logic       evt_ready;
  logic [1:0] evt_id;
  logic       overrun;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  btn_event_ctrl #(
    .N_BTN(4),
    .TICK_DIV(4),
    .STABLE_SAMPLES(3)
`ifdef BTN_AUTOREPEAT_EN
    , .REPEAT_TICKS(5)
`endif
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .btn_in   (btn_in),
    .btn_level(btn_level),
    .evt_valid(evt_valid),
    .evt_ready(evt_ready),
    .evt_id   (evt_id),
    .overrun  (overrun)
  );

  // Inputs are driven and outputs sampled 1 time unit after each rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic steps(input int n);
    repeat (n) step();
  endtask

  // Leaves the bench just after edge e0, the last edge with rst high.
  task automatic do_reset();
    rst = 1'b1;
    btn_in = 4'b0000;
    evt_ready = 1'b0;
    steps(2);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++;
    if ({btn_level, evt_valid, evt_id, overrun} !== 8'h00) begin
      n_err++;
      $display("FAIL reset_state: level=%b valid=%b id=%0d overrun=%b, want all 0",
               btn_level, evt_valid, evt_id, overrun);
    end
  endtask

  task automatic test_clean_press();
    do_reset();
    btn_in = 4'b0001;
    steps(11);
    n_cmp++;
    if (btn_level[0] !== 1'b0) begin
      n_err++; $display("FAIL clean_level_early: got %b want 0", btn_level[0]);
    end
    step();
    n_cmp++;
    if (btn_level[0] !== 1'b1) begin
      n_err++; $display("FAIL clean_level_rise: got %b want 1", btn_level[0]);
    end
    step();
    n_cmp++;
    if (evt_valid !== 1'b0) begin
      n_err++; $display("FAIL clean_valid_early: got %b want 0", evt_valid);
    end
    step();
    n_cmp++;
    if ({evt_valid, evt_id} !== {1'b1, 2'd0}) begin
      n_err++; $display("FAIL clean_valid_rise: valid=%b id=%0d want 1/0", evt_valid, evt_id);
    end
    for (int k = 0; k < 10; k++) begin
      step();
      n_cmp++;
      if ({evt_valid, evt_id} !== {1'b1, 2'd0}) begin
        n_err++; $display("FAIL clean_hold_%0d: valid=%b id=%0d want 1/0", k, evt_valid, evt_id);
      end
    end
    evt_ready = 1'b1;
    step();
    n_cmp++;
    if (evt_valid !== 1'b0) begin
      n_err++; $display("FAIL clean_drop: valid=%b want 0", evt_valid);
    end
    btn_in = 4'b0000;
    evt_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic early;
    do_reset();
    btn_in = 4'b0100;
    steps(16);
    n_cmp++;
    if ({evt_valid, evt_id} !== {1'b1, 2'd2}) begin
      n_err++; $display("FAIL midrst_pre: valid=%b id=%0d want 1/2", evt_valid, evt_id);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_cmp++;
    if ({evt_valid, btn_level, overrun, evt_id} !== 8'h00) begin
      n_err++;
      $display("FAIL midrst_state: valid=%b level=%b overrun=%b id=%0d want all 0",
               evt_valid, btn_level, overrun, evt_id);
    end
    early = 1'b0;
    for (int k = 0; k < 13; k++) begin
      step();
      if (evt_valid) early = 1'b1;
    end
    n_cmp++;
    if (early !== 1'b0) begin
      n_err++; $display("FAIL midrst_early_event: got %b want 0", early);
    end
    step();
    n_cmp++;
    if ({evt_valid, evt_id} !== {1'b1, 2'd2}) begin
      n_err++; $display("FAIL midrst_redebounce: valid=%b id=%0d want 1/2", evt_valid, evt_id);
    end
    btn_in = 4'b0000;
  endtask

  task automatic test_bounce();
    int n_evt;
    logic [1:0] last_id;
    do_reset();
    evt_ready = 1'b1;
    n_evt = 0;
    last_id = 2'd0;
    for (int c = 0; c < 92; c++) begin
      if (c < 40)      btn_in[1] = ((c / 3) % 2 == 0);
      else if (c < 52) btn_in[1] = 1'b1;
      else             btn_in[1] = 1'b0;
      if (evt_valid && evt_ready) begin
        n_evt++;
        last_id = evt_id;
      end
      step();
    end
    n_cmp++;
    if (n_evt !== 1) begin
      n_err++; $display("FAIL bounce_count: got %0d events want 1", n_evt);
    end
    n_cmp++;
    if (last_id !== 2'd1) begin
      n_err++; $display("FAIL bounce_id: got %0d want 1", last_id);
    end
    evt_ready = 1'b0;
  endtask

  task automatic test_simultaneous();
    do_reset();
    evt_ready = 1'b1;
    for (int r = 0; r < 2; r++) begin
      btn_in = 4'b0101;
      steps(14);
      n_cmp++;
      if ({evt_valid, evt_id} !== {1'b1, 2'd0}) begin
        n_err++; $display("FAIL simul%0d_first: valid=%b id=%0d want 1/0", r, evt_valid, evt_id);
      end
      step();
      n_cmp++;
      if ({evt_valid, evt_id} !== {1'b1, 2'd2}) begin
        n_err++; $display("FAIL simul%0d_second: valid=%b id=%0d want 1/2", r, evt_valid, evt_id);
      end
      step();
      n_cmp++;
      if (evt_valid !== 1'b0) begin
        n_err++; $display("FAIL simul%0d_idle: valid=%b want 0", r, evt_valid);
      end
      btn_in = 4'b0000;
      steps(24);
    end
    evt_ready = 1'b0;
  endtask

  task automatic test_overrun();
    int n_evt;
    logic [1:0] ids [2];
    do_reset();
    btn_in = 4'b0001;
    steps(16);
    n_cmp++;
    if ({evt_valid, evt_id} !== {1'b1, 2'd0}) begin
      n_err++; $display("FAIL ovr_pre: valid=%b id=%0d want 1/0", evt_valid, evt_id);
    end
    btn_in = 4'b1000;
    steps(16);
    n_cmp++;
    if (overrun !== 1'b0) begin
      n_err++; $display("FAIL ovr_first_press: overrun=%b want 0", overrun);
    end
    btn_in = 4'b0000;
    steps(16);
    btn_in = 4'b1000;
    steps(16);
    n_cmp++;
    if (overrun !== 1'b1) begin
      n_err++; $display("FAIL ovr_set: overrun=%b want 1", overrun);
    end
    evt_ready = 1'b1;
    n_evt = 0;
    ids[0] = 2'd0;
    ids[1] = 2'd0;
    for (int k = 0; k < 8; k++) begin
      if (evt_valid && evt_ready) begin
        if (n_evt < 2) ids[n_evt] = evt_id;
        n_evt++;
      end
      step();
    end
    n_cmp++;
    if (n_evt !== 2 || ids[0] !== 2'd0 || ids[1] !== 2'd3) begin
      n_err++;
      $display("FAIL ovr_events: got %0d events ids %0d,%0d want 2 events ids 0,3",
               n_evt, ids[0], ids[1]);
    end
    n_cmp++;
    if (overrun !== 1'b1) begin
      n_err++; $display("FAIL ovr_sticky: overrun=%b want 1", overrun);
    end
    btn_in = 4'b0000;
    evt_ready = 1'b0;
    do_reset();
    n_cmp++;
    if (overrun !== 1'b0) begin
      n_err++; $display("FAIL ovr_reset_clear: overrun=%b want 0", overrun);
    end
  endtask

  task automatic test_autorepeat();
    int n_evt;
    int t [8];
    do_reset();
    evt_ready = 1'b1;
    btn_in = 4'b0001;
    n_evt = 0;
    for (int k = 0; k < 8; k++) t[k] = 0;
    for (int e = 0; e < 80; e++) begin
      if (evt_valid && evt_ready) begin
        if (n_evt < 8) t[n_evt] = e + 1;
        n_evt++;
      end
      step();
    end
    n_cmp++;
    if (t[0] !== 15) begin
      n_err++; $display("FAIL rep_first_edge: handshake at edge %0d want 15", t[0]);
    end
`ifdef BTN_AUTOREPEAT_EN
    n_cmp++;
    if (n_evt !== 4) begin
      n_err++; $display("FAIL rep_count: got %0d events want 4", n_evt);
    end
    for (int k = 1; k < 4; k++) begin
      n_cmp++;
      if (t[k] - t[k-1] !== 20) begin
        n_err++; $display("FAIL rep_period_%0d: got %0d clk want 20", k, t[k] - t[k-1]);
      end
    end
`else
    n_cmp++;
    if (n_evt !== 1) begin
      n_err++; $display("FAIL rep_single: got %0d events want 1", n_evt);
    end
`endif
    btn_in = 4'b0000;
    evt_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    btn_in = 4'b0000;
    evt_ready = 1'b0;
    test_reset();
    test_clean_press();
    test_reset_mid();
    test_bounce();
    test_simultaneous();
    test_overrun();
    test_autorepeat();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
